// File: rtl/regfile_writer_pkg.sv
// Shared definitions for the register-file write side.
// Holds the register address width, register count, default datapath width,
// the x0 index, the write-source selector used by the priority mux, and a
// small helper that tests for the hard-wired zero register.
package regfile_writer_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int REG_COUNT    = 32;
  localparam int XLEN_DEFAULT = 32;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  // Which source owns the bank write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LOAD = 2'd2
  } wr_src_e;

  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
    return rd == X0;
  endfunction

endpackage

// File: rtl/regfile_writer_fifo.sv
// wb_fifo: synchronous FIFO of {stale, rd, data} for buffered load results.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   push_i/push_rd_i/push_data_i - enqueue at tail (ignored when full)
//   pop_i             - dequeue head (ignored when empty)
//   mark_i/mark_rd_i  - mark every held entry targeting mark_rd_i stale;
//                       a same-cycle push to that rd is stored already stale
//   head_stale_o/head_rd_o/head_data_o - current head entry
//   full_o, empty_o, count_o - occupancy (live + stale entries)
//   live_o            - bit r set iff a held, non-stale entry targets r
module wb_fifo
  import regfile_writer_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic [REG_ADDR_W-1:0]     push_rd_i,
  input  logic [XLEN-1:0]           push_data_i,
  input  logic                      pop_i,
  input  logic                      mark_i,
  input  logic [REG_ADDR_W-1:0]     mark_rd_i,
  output logic                      head_stale_o,
  output logic [REG_ADDR_W-1:0]     head_rd_o,
  output logic [XLEN-1:0]           head_data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [REG_COUNT-1:0]      live_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic [DEPTH-1:0]      valid_q, stale_q;
  logic [DEPTH-1:0]      slot_live;
  logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]       data_mem [DEPTH];
  logic                  push_en, pop_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};
    end
  end

  // Payload storage carries no reset; occupancy is tracked by valid_q.
  always_ff @(posedge clock) begin
    if (push_en) begin
      rd_mem[wr_ptr_q]   <= push_rd_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

  // Per-slot occupancy and stale flags. A slot being pushed can never be
  // held already (FIFO not full), so the push branch owns its stale bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      stale_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_en && wr_ptr_q == AW'(i)) begin
          valid_q[i] <= 1'b1;
          stale_q[i] <= mark_i && (push_rd_i == mark_rd_i);
        end else begin
          if (pop_en && rd_ptr_q == AW'(i)) valid_q[i] <= 1'b0;
          if (mark_i && valid_q[i] && rd_mem[i] == mark_rd_i) stale_q[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign slot_live[gi] = valid_q[gi] & ~stale_q[gi];
  end

  always_comb begin
    live_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_live[i]) live_o[rd_mem[i]] = 1'b1;
    end
  end

  assign head_stale_o = stale_q[rd_ptr_q];
  assign head_rd_o    = rd_mem[rd_ptr_q];
  assign head_data_o  = data_mem[rd_ptr_q];

endmodule

// File: rtl/regfile_writer.sv
// regfile_writer: write-side master for registers_bank.
// Merges single-cycle ALU results (always accepted, highest priority) and
// buffered load results into one registered bank write per cycle.
// Ports:
//   clock, reset                  - rising-edge clock, sync active-high reset
//   alu_valid/alu_rd/alu_data     - ALU result for this cycle
//   load_valid/load_ready/load_rd/load_data - load result handshake
//   rf_we/rf_sel_in/rf_data_in    - registered bank write port
//   busy                          - registers with live buffered loads
//   fifo_count                    - entries held (live + stale)
module regfile_writer
  import regfile_writer_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    alu_valid,
  input  logic [REG_ADDR_W-1:0]   alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [REG_ADDR_W-1:0]   load_rd,
  input  logic [XLEN-1:0]         load_data,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_sel_in,
  output logic [XLEN-1:0]         rf_data_in,
  output logic [REG_COUNT-1:0]    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  wr_src_e               src;
  logic                  push, pop, mark;
  logic                  head_stale;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  fifo_full, fifo_empty;
  logic [REG_COUNT-1:0]  live;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_sel_q, rf_sel_d;
  logic [XLEN-1:0]       rf_data_q, rf_data_d;

  assign load_ready = ~fifo_full;
  // x0 loads complete the handshake but never occupy an entry.
  assign push = load_valid & load_ready & ~is_x0(load_rd);
  // An ALU write is younger than anything buffered, so it supersedes them.
  assign mark = alu_valid & ~is_x0(alu_rd);
  assign pop  = (src == SRC_LOAD);

  always_comb begin
    src = SRC_NONE;
    if (alu_valid)        src = SRC_ALU;
    else if (!fifo_empty) src = SRC_LOAD;
  end

  wb_fifo #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_rd_i   (load_rd),
    .push_data_i (load_data),
    .pop_i       (pop),
    .mark_i      (mark),
    .mark_rd_i   (alu_rd),
    .head_stale_o(head_stale),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .live_o      (live)
  );

  always_comb begin
    rf_we_d   = 1'b0;
    rf_sel_d  = rf_sel_q;
    rf_data_d = rf_data_q;
    case (src)
      SRC_ALU: begin
        rf_we_d   = ~is_x0(alu_rd);
        rf_sel_d  = alu_rd;
        rf_data_d = alu_data;
      end
      SRC_LOAD: begin
        // A stale entry still consumes its slot but must not write.
        rf_we_d   = ~head_stale;
        rf_sel_d  = head_rd;
        rf_data_d = head_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we_q   <= 1'b0;
      rf_sel_q  <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_sel_q  <= rf_sel_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_sel_in  = rf_sel_q;
  assign rf_data_in = rf_data_q;
  assign busy       = {live[REG_COUNT-1:1], 1'b0};

endmodule

// File: tb/tb_regfile_writer.sv
module tb_regfile_writer;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic        rf_we;
  logic [4:0]  rf_sel_in;
  logic [31:0] rf_data_in;
  logic [31:0] busy;
  logic [2:0]  fifo_count;

  int n_vec  = 0;
  int n_miss = 0;

  regfile_writer #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_rd   (load_rd),
    .load_data (load_data),
    .rf_we     (rf_we),
    .rf_sel_in (rf_sel_in),
    .rf_data_in(rf_data_in),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  // Reference model: an ordered list of pending loads plus the last write.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          stale;
  } ment_t;

  ment_t       mq[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_sel  = '0;
  logic [31:0] m_data = '0;

  typedef struct {
    logic        av;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        exp_we;
    logic [4:0]  exp_sel;
    logic [31:0] exp_data;
  } alu_vec_t;

  alu_vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    ment_t e;
    bit    accept;
    if (reset) begin
      mq.delete();
      m_we = 1'b0; m_sel = '0; m_data = '0;
      return;
    end
    accept = load_valid && (mq.size() < DEPTH);
    if (alu_valid) begin
      m_we = (alu_rd != 0); m_sel = alu_rd; m_data = alu_data;
      if (alu_rd != 0)
        foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].stale = 1'b1;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = !e.stale; m_sel = e.rd; m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (accept && load_rd != 0) begin
      e.rd = load_rd; e.data = load_data;
      e.stale = alu_valid && (alu_rd == load_rd);
      mq.push_back(e);
    end
  endtask

  task automatic compare_model();
    logic [31:0] b;
    b = '0;
    foreach (mq[i]) if (!mq[i].stale) b[mq[i].rd] = 1'b1;
    check("rf_we",      32'(rf_we),      32'(m_we));
    check("rf_sel_in",  32'(rf_sel_in),  32'(m_sel));
    check("rf_data_in", rf_data_in,      m_data);
    check("busy",       busy,            b);
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("load_ready", 32'(load_ready), 32'(mq.size() < DEPTH));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    if (rf_we) $display("t=%0t write x%0d <= %h", $time, rf_sel_in, rf_data_in);
    compare_model();
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    load_valid = 0; load_rd = '0; load_data = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    tbl[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  32'h12345678};
    tbl[2] = '{1'b0, 5'd9,  32'h0000CAFE, 1'b0, 5'd0,  32'h12345678};
    tbl[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
    tbl[4] = '{1'b0, 5'd3,  32'h00000000, 1'b0, 5'd31, 32'hFFFFFFFF};

    // Reset held 3 cycles while a load is offered.
    idle();
    reset = 1; load_valid = 1; load_rd = 5'd3; load_data = 32'h55;
    for (int i = 0; i < 3; i++) tick();
    check("rst_we",    32'(rf_we), 32'd0);
    check("rst_sel",   32'(rf_sel_in), 32'd0);
    check("rst_data",  rf_data_in, 32'd0);
    check("rst_busy",  busy, 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    reset = 0; idle();
    tick();
    check("rst_noacc", 32'(rf_we), 32'd0);

    // ALU-only table.
    for (int i = 0; i < 5; i++) begin
      alu_valid = tbl[i].av; alu_rd = tbl[i].rd; alu_data = tbl[i].d;
      tick();
      check("alu_tbl_we",   32'(rf_we),     32'(tbl[i].exp_we));
      check("alu_tbl_sel",  32'(rf_sel_in), 32'(tbl[i].exp_sel));
      check("alu_tbl_data", rf_data_in,     tbl[i].exp_data);
    end
    idle();

    // Load path latency.
    load_valid = 1; load_rd = 5'd7; load_data = 32'h11;
    tick();
    check("ld_busy7",  32'(busy[7]), 32'd1);
    check("ld_count",  32'(fifo_count), 32'd1);
    idle();
    tick();
    check("ld_we",   32'(rf_we), 32'd1);
    check("ld_sel",  32'(rf_sel_in), 32'd7);
    check("ld_data", rf_data_in, 32'h11);
    tick();
    check("ld_busy7_clr", 32'(busy[7]), 32'd0);

    // Backpressure with ALU priority.
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1; alu_rd = 5'd20; alu_data = 32'h100 + 32'(i);
      load_valid = 1; load_rd = 5'(i); load_data = 32'hA0 + 32'(i);
      tick();
    end
    check("bp_ready", 32'(load_ready), 32'd0);
    check("bp_count", 32'(fifo_count), 32'd4);
    idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("bp_we",  32'(rf_we), 32'd1);
      check("bp_sel", 32'(rf_sel_in), 32'(i));
    end

    // WAW: load to x9 then a younger ALU write to x9.
    load_valid = 1; load_rd = 5'd9; load_data = 32'hAA;
    tick();
    idle();
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'hBB;
    tick();
    check("waw_data",  rf_data_in, 32'hBB);
    check("waw_busy9", 32'(busy[9]), 32'd0);
    idle();
    tick();
    check("waw_stale_we", 32'(rf_we), 32'd0);

    // WAW with the load accepted in the same cycle as the ALU write.
    load_valid = 1; load_rd = 5'd9; load_data = 32'hAA;
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'hBB;
    tick();
    check("waw2_data",  rf_data_in, 32'hBB);
    check("waw2_busy9", 32'(busy[9]), 32'd0);
    check("waw2_count", 32'(fifo_count), 32'd1);
    idle();
    tick();
    check("waw2_stale_we", 32'(rf_we), 32'd0);

    // Load to x0 is accepted but dropped.
    load_valid = 1; load_rd = 5'd0; load_data = 32'h77;
    tick();
    check("x0_count", 32'(fifo_count), 32'd0);
    idle();
    tick();
    check("x0_we", 32'(rf_we), 32'd0);

    // Reset with three buffered entries.
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 5'd21; alu_data = 32'(i);
      load_valid = 1; load_rd = 5'(11 + i); load_data = 32'hC0 + 32'(i);
      tick();
    end
    check("mr_count", 32'(fifo_count), 32'd3);
    idle();
    reset = 1;
    tick();
    check("mr_count0", 32'(fifo_count), 32'd0);
    check("mr_busy0",  busy, 32'd0);
    reset = 0;
    tick();
    check("mr_nowr", 32'(rf_we), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 63) == 0);
      alu_valid  = ($urandom_range(0, 9) < 4);
      alu_rd     = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      load_valid = ($urandom_range(0, 9) < 6);
      load_rd    = 5'($urandom_range(0, 7));
      load_data  = $urandom;
      tick();
    end
    reset = 0; idle();
    for (int c = 0; c < 6; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
